elpis_sram_arbiter: RTL and testbench

Shares the single-port custom SRAM (512 x 32) between three requesters: the Wishbone slave path from the management SoC (program load and result readback), the Elpis core instruction-fetch port and the Elpis core data port. It grants at most one access per clock and drives the SRAM control pins. It returns read data with a fixed one-cycle latency and generates the Wishbone acknowledge. It sits in the user project wrapper between the Wishbone slave interface, core0 and custom_sram.

---
 rtl/elpis_sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_elpis_sram_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/elpis_sram_arbiter.sv
// elpis_sram_arbiter: shares one single-port 512x32 SRAM between the
// Wishbone slave path, the Elpis instruction-fetch port and the Elpis data
// port. One access is granted per clock; read data returns one cycle later.
module elpis_sram_arbiter #(
    parameter int unsigned ADDR_W  = 9,
    parameter logic [31:0] WB_BASE = 32'h3000_0000,
    parameter logic [31:0] WB_MASK = 32'hFFFF_F800
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // Wishbone slave
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    // Instruction fetch port (read only)
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    // Core data port
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_be_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [31:0]       dm_rdata_o,
    // SRAM macro pins
    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [3:0]        sram_wmask_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_din_o,
    input  logic [31:0]       sram_dout_i
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_DM   = 2'd2,
        SRC_IF   = 2'd3
    } src_e;

    logic              wb_req;
    logic              wb_hit;
    logic [ADDR_W-1:0] wb_word;

    src_e              gnt_src;
    logic              rr_ptr_q, rr_ptr_d;     // 0: data port preferred, 1: fetch preferred
    src_e              rsp_src_q, rsp_src_d;
    logic              rsp_rd_q, rsp_rd_d;
    logic              wb_miss_q, wb_miss_d;

    // Wishbone request decode; the ack cycle masks the still-asserted strobe
    assign wb_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wb_hit  = ((wbs_adr_i & WB_MASK) == WB_BASE);
    assign wb_word = wbs_adr_i[ADDR_W+1:2];

    // Pick this cycle's winner and the next round-robin pointer
    always_comb begin
        gnt_src  = SRC_NONE;
        rr_ptr_d = rr_ptr_q;
        if (!wb_rst_i) begin
            if (wb_req && wb_hit) begin
                gnt_src = SRC_WB;
            end else if (dm_req_i && if_req_i) begin
                gnt_src  = rr_ptr_q ? SRC_IF : SRC_DM;
                rr_ptr_d = ~rr_ptr_q;
            end else if (dm_req_i) begin
                gnt_src = SRC_DM;
            end else if (if_req_i) begin
                gnt_src = SRC_IF;
            end
        end
    end

    // Drive the SRAM pins and grants from the winner
    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_wmask_o = BE_W'(0);
        sram_addr_o  = ADDR_W'(0);
        sram_din_o   = DATA_W'(0);
        if_gnt_o     = 1'b0;
        dm_gnt_o     = 1'b0;
        unique case (gnt_src)
            SRC_WB: begin
                sram_csb_o   = 1'b0;
                sram_web_o   = ~wbs_we_i;
                sram_wmask_o = wbs_sel_i;
                sram_addr_o  = wb_word;
                sram_din_o   = wbs_dat_i;
            end
            SRC_DM: begin
                dm_gnt_o     = 1'b1;
                sram_csb_o   = 1'b0;
                sram_web_o   = ~dm_we_i;
                sram_wmask_o = dm_be_i;
                sram_addr_o  = dm_addr_i;
                sram_din_o   = dm_wdata_i;
            end
            SRC_IF: begin
                if_gnt_o     = 1'b1;
                sram_csb_o   = 1'b0;
                sram_addr_o  = if_addr_i;
            end
            default: begin
            end
        endcase
    end

    // Next response tag: who was granted and whether it was a read
    always_comb begin
        rsp_src_d = gnt_src;
        rsp_rd_d  = 1'b0;
        wb_miss_d = ~wb_rst_i & wb_req & ~wb_hit;
        unique case (gnt_src)
            SRC_WB:  rsp_rd_d = ~wbs_we_i;
            SRC_DM:  rsp_rd_d = ~dm_we_i;
            SRC_IF:  rsp_rd_d = 1'b1;
            default: rsp_rd_d = 1'b0;
        endcase
    end

    // Response tag and round-robin pointer registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rr_ptr_q  <= 1'b0;
            rsp_src_q <= SRC_NONE;
            rsp_rd_q  <= 1'b0;
            wb_miss_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rsp_src_q <= rsp_src_d;
            rsp_rd_q  <= rsp_rd_d;
            wb_miss_q <= wb_miss_d;
        end
    end

    // Response decode; SRAM data is valid in the cycle after the command
    assign wbs_ack_o   = (rsp_src_q == SRC_WB) | wb_miss_q;
    assign wbs_dat_o   = ((rsp_src_q == SRC_WB) && rsp_rd_q) ? sram_dout_i : DATA_W'(0);
    assign if_rvalid_o = (rsp_src_q == SRC_IF);
    assign if_rdata_o  = sram_dout_i;
    assign dm_rvalid_o = (rsp_src_q == SRC_DM) & rsp_rd_q;
    assign dm_rdata_o  = sram_dout_i;

endmodule

// File: tb/tb_elpis_sram_arbiter.sv
// Directed bench for elpis_sram_arbiter with a behavioural 512x32 SRAM.
module tb_elpis_sram_arbiter;

    localparam int unsigned ADDR_W = 9;

    logic              clk;
    logic              rst;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       adr, dat_w;
    logic              ack;
    logic [31:0]       dat_r;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              dm_req, dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt, dm_rvalid;
    logic [31:0]       dm_rdata;
    logic              csb, web;
    logic [3:0]        wmask;
    logic [ADDR_W-1:0] saddr;
    logic [31:0]       din, dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:511];

    elpis_sram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
        .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid),
        .dm_rdata_o(dm_rdata),
        .sram_csb_o(csb), .sram_web_o(web), .sram_wmask_o(wmask),
        .sram_addr_o(saddr), .sram_din_o(din), .sram_dout_i(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: byte-masked write, registered read
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) mem[saddr][8*b +: 8] <= din[8*b +: 8];
            end else begin
                dout <= mem[saddr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant-side pins: csb, web, if_gnt, dm_gnt
    task automatic chk_gnt(input string tag, input logic e_csb, input logic e_web,
                           input logic e_ifg, input logic e_dmg);
        chk({tag, ".csb"},    32'(csb),    32'(e_csb));
        chk({tag, ".web"},    32'(web),    32'(e_web));
        chk({tag, ".if_gnt"}, 32'(if_gnt), 32'(e_ifg));
        chk({tag, ".dm_gnt"}, 32'(dm_gnt), 32'(e_dmg));
    endtask

    // Response-side pins: ack, if_rvalid, dm_rvalid
    task automatic chk_rsp(input string tag, input logic e_ack, input logic e_ifv, input logic e_dmv);
        chk({tag, ".ack"},       32'(ack),       32'(e_ack));
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(e_ifv));
        chk({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'(e_dmv));
    endtask

    task automatic idle();
        cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_be = 4'h0; dm_addr = '0; dm_wdata = 32'h0;
    endtask

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d);
        cyc = 1; stb = 1; we = w; sel = 4'hF; adr = a; dat_w = d;
    endtask

    // Advance to the next falling edge and let combinational outputs settle
    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[1] = 32'h1111_0001;
        mem[2] = 32'h2222_0002;
        dout = 32'h0;
        idle();
        rst = 1;
        wb(1, 32'h3000_0010, 32'hDEAD_BEEF);
        if_req = 1; if_addr = 9'd1;
        dm_req = 1; dm_addr = 9'd2;

        // Reset held 3 cycles with every requester active
        for (int i = 0; i < 3; i++) begin
            next(); #1;
            chk_gnt("rst", 1, 1, 0, 0);
            chk_rsp("rst", 0, 0, 0);
        end

        // Release: Wishbone write wins over both cores
        next(); rst = 0; #1;
        chk_gnt("wbw", 0, 0, 0, 0);
        chk("wbw.addr", 32'(saddr), 32'd4);
        chk("wbw.din", din, 32'hDEAD_BEEF);
        chk("wbw.wmask", 32'(wmask), 32'hF);
        chk_rsp("wbw", 0, 0, 0);

        // Ack cycle: strobe still up but masked, cores now idle
        next(); if_req = 0; dm_req = 0; #1;
        chk_rsp("wbw_ack", 1, 0, 0);
        chk_gnt("wbw_ack", 1, 1, 0, 0);

        // Wishbone read-back
        next(); wb(0, 32'h3000_0010, 32'h0); #1;
        chk_rsp("wbr", 0, 0, 0);
        chk_gnt("wbr", 0, 1, 0, 0);
        chk("wbr.addr", 32'(saddr), 32'd4);
        next(); #1;
        chk_rsp("wbr_ack", 1, 0, 0);
        chk("wbr.dat", dat_r, 32'hDEAD_BEEF);
        chk_gnt("wbr_ack", 1, 1, 0, 0);
        next(); idle(); #1;
        chk_rsp("wbr_done", 0, 0, 0);

        // Round robin: both core ports requesting for 6 cycles
        if_req = 1; if_addr = 9'd1; dm_req = 1; dm_addr = 9'd2;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next();
            #1;
            chk_gnt($sformatf("rr%0d", i), 0, 1, (i % 2) == 1, (i % 2) == 0);
            chk($sformatf("rr%0d.addr", i), 32'(saddr), (i % 2) == 0 ? 32'd2 : 32'd1);
            chk_rsp($sformatf("rr%0d", i), 0, (i > 0) && ((i % 2) == 0), (i % 2) == 1);
            if (i % 2 == 1) chk($sformatf("rr%0d.dm_rdata", i), dm_rdata, 32'h2222_0002);
            if (i > 0 && i % 2 == 0) chk($sformatf("rr%0d.if_rdata", i), if_rdata, 32'h1111_0001);
            if (i == 5) begin
                @(posedge clk);
            end
        end
        @(negedge clk); idle(); #1;
        chk_rsp("rr_end", 0, 1, 0);
        chk("rr_end.if_rdata", if_rdata, 32'h1111_0001);
        chk_gnt("rr_end", 1, 1, 0, 0);

        // Wishbone write collides with both core reads of the same word
        next();
        wb(1, 32'h3000_0020, 32'h5555_AAAA);
        if_req = 1; if_addr = 9'd8; dm_req = 1; dm_addr = 9'd8; #1;
        chk_gnt("coll_wb", 0, 0, 0, 0);
        chk("coll_wb.addr", 32'(saddr), 32'd8);
        next(); #1;
        chk_rsp("coll_dm", 1, 0, 0);
        chk_gnt("coll_dm", 0, 1, 0, 1);
        next(); cyc = 0; stb = 0; #1;
        chk_rsp("coll_if", 0, 0, 1);
        chk("coll_if.dm_rdata", dm_rdata, 32'h5555_AAAA);
        chk_gnt("coll_if", 0, 1, 1, 0);
        next(); idle(); #1;
        chk_rsp("coll_end", 0, 1, 0);
        chk("coll_end.if_rdata", if_rdata, 32'h5555_AAAA);

        // Byte-masked core write over a preloaded word
        next(); wb(1, 32'h3000_001C, 32'h1234_5678); #1;
        chk_gnt("pre", 0, 0, 0, 0);
        next(); #1;
        chk_rsp("pre_ack", 1, 0, 0);
        next(); idle();
        dm_req = 1; dm_we = 1; dm_be = 4'b0001; dm_addr = 9'd7; dm_wdata = 32'h0000_00AA; #1;
        chk_gnt("bw", 0, 0, 0, 1);
        chk("bw.wmask", 32'(wmask), 32'h1);
        chk("bw.din", din, 32'h0000_00AA);
        next(); idle(); if_req = 1; if_addr = 9'd7; #1;
        chk_rsp("bw_rd", 0, 0, 0);
        chk_gnt("bw_rd", 0, 1, 1, 0);
        next(); idle(); #1;
        chk_rsp("bw_chk", 0, 1, 0);
        chk("bw_chk.if_rdata", if_rdata, 32'h1234_56AA);

        // Wishbone miss alone: no SRAM access, ack with zero data
        next(); wb(0, 32'h2000_0000, 32'h0); #1;
        chk_gnt("miss", 1, 1, 0, 0);
        next(); #1;
        chk_rsp("miss_ack", 1, 0, 0);
        chk("miss.dat", dat_r, 32'h0);
        chk_gnt("miss_ack", 1, 1, 0, 0);

        // Wishbone miss with a concurrent fetch: fetch granted same cycle
        next(); idle(); #1;
        chk_rsp("miss_gap", 0, 0, 0);
        next(); wb(0, 32'h2000_0000, 32'h0); if_req = 1; if_addr = 9'd7; #1;
        chk_gnt("miss_if", 0, 1, 1, 0);
        chk("miss_if.addr", 32'(saddr), 32'd7);
        next(); if_req = 0; #1;
        chk_rsp("miss_if_rsp", 1, 1, 0);
        chk("miss_if.dat", dat_r, 32'h0);
        chk("miss_if.if_rdata", if_rdata, 32'h1234_56AA);
        next(); idle(); #1;
        chk_rsp("miss_done", 0, 0, 0);

        // Reset asserted after a data read grant drops its rvalid
        next(); dm_req = 1; dm_addr = 9'd7; #1;
        chk_gnt("rst_mid", 0, 1, 0, 1);
        #2 rst = 1;
        next(); #1;
        chk_rsp("rst_mid", 0, 0, 0);
        chk_gnt("rst_mid_hold", 1, 1, 0, 0);
        next(); rst = 0; idle(); #1;
        chk_gnt("post_rst", 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
